pipe_hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. Sits beside the ID stage and drives the stall/bubble controls into the PC, IF/ID and ID/EX registers. Detects load-use hazards and branch flushes, and schedules the multi-cycle multiply/divide unit that writes HI/LO. Stalls HI/LO readers and back-to-back mult/div issues until the unit finishes.

---
 rtl/pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard controller for the 5-stage MIPS core. Sits beside ID and produces
// the stall / bubble controls for PC, IF/ID and ID/EX. It detects load-use
// hazards and taken-branch flushes. It also sequences the multi-cycle
// mult/div unit that writes HI/LO: mfhi/mflo and a second mult/div are held
// in ID while that unit is busy.
//
// Configuration macro: HAZARD_CTRL_DIV_EN
//   defined   - id_is_div is honoured; divides run for DIV_LAT cycles.
//   undefined - id_is_div is ignored, md_is_div stays 0, and every operation
//               runs for MULT_LAT cycles.
//
// Parameters
//   MULT_LAT      mult/multu latency in cycles (2..31)
//   DIV_LAT       div/divu latency in cycles (2..31); used only when the
//                 divide path is enabled
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   id_ra, id_rb    source registers of the instruction in ID
//   id_uses_rb      the ID instruction reads rb
//   id_branch_taken the branch/jump in ID resolved taken
//   id_md_req       ID holds mult/multu/div/divu
//   id_is_div       marks id_md_req as a divide
//   id_reads_hl     ID holds mfhi/mflo
//   ex_rw           destination register of the instruction in EX
//   ex_memtoreg     EX memtoreg select (2'd1 = load)
//   ex_regWr        the EX instruction writes the register file
//   pc_stall        hold PC
//   ifid_stall      hold IF/ID
//   hazard          insert a bubble into ID/EX
//   BranchBubble    flush the wrong-path instruction
//   md_start        one-cycle start pulse to the mult/div unit
//   md_is_div       operation type latched with md_start
//   md_busy         the mult/div unit is running
//   md_done         pulse on the final busy cycle (HI/LO are written there)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_ra,
    input  logic [4:0] id_rb,
    input  logic       id_uses_rb,
    input  logic       id_branch_taken,
    input  logic       id_md_req,
    input  logic       id_is_div,
    input  logic       id_reads_hl,
    input  logic [4:0] ex_rw,
    input  logic [1:0] ex_memtoreg,
    input  logic       ex_regWr,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       hazard,
    output logic       BranchBubble,
    output logic       md_start,
    output logic       md_is_div,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The counter is loaded with LAT-1 so that RUN lasts exactly LAT cycles.
    localparam logic [4:0] MULT_LOAD = 5'(MULT_LAT - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [4:0] cnt_r;
    logic [4:0] cnt_nxt_s;
    logic       md_is_div_r;
    logic       md_is_div_nxt_s;
    logic       div_sel_s;
    logic [4:0] lat_load_s;
    logic       lu_s;
    logic       stall_s;
    logic       busy_s;

`ifdef HAZARD_CTRL_DIV_EN
    localparam logic [4:0] DIV_LOAD = 5'(DIV_LAT - 1);
    assign div_sel_s  = id_is_div;
    assign lat_load_s = id_is_div ? DIV_LOAD : MULT_LOAD;
`else
    // Divide path compiled out: every operation is treated as a multiply.
    logic unused_div_s;
    assign unused_div_s = id_is_div ^ (DIV_LAT == 0);
    assign div_sel_s    = 1'b0;
    assign lat_load_s   = MULT_LOAD;
`endif

    // Load-use: a load in EX writes a register the ID instruction reads ($0 never hazards).
    assign lu_s = ex_regWr & (ex_memtoreg == 2'd1) & (ex_rw != 5'd0) &
                  ((ex_rw == id_ra) | (id_uses_rb & (ex_rw == id_rb)));

    // Held in reset the unit reads as idle, so no start/done can escape during an abort.
    assign busy_s = rst_n & (state_r == ST_RUN);

    // Stall sources: load-use, HI/LO reader while busy, second mult/div while busy.
    assign stall_s = lu_s | (id_reads_hl & busy_s) | (id_md_req & busy_s);

    // State register: FSM state, latency counter and latched operation type.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            md_is_div_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            md_is_div_r <= md_is_div_nxt_s;
        end
    end

    // Next-state logic: issue from IDLE, count down in RUN.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        md_is_div_nxt_s = md_is_div_r;
        case (state_r)
            ST_IDLE: begin
                // A load-use bubble defers the issue; the request retries next cycle.
                if (id_md_req & ~lu_s) begin
                    state_nxt_s     = ST_RUN;
                    cnt_nxt_s       = lat_load_s;
                    md_is_div_nxt_s = div_sel_s;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r != 5'd0) begin
                    cnt_nxt_s   = cnt_r - 5'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 5'd0;
            end
        endcase
    end

    // Output decode: stall/bubble controls and mult/div handshake.
    always_comb begin
        pc_stall     = stall_s;
        ifid_stall   = stall_s;
        hazard       = stall_s;
        // A stalled branch re-resolves once its operands are valid.
        BranchBubble = id_branch_taken & ~stall_s;
        md_is_div    = md_is_div_r;
        md_start     = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                md_start = rst_n & id_md_req & ~lu_s;
            end
            ST_RUN: begin
                md_busy = rst_n;
                md_done = rst_n & (cnt_r == 5'd0);
            end
            default: begin
                md_start = 1'b0;
            end
        endcase
    end

endmodule
